adp_debug_bridge: RTL and testbench

System-clock bridge directly downstream of the ADP TAP controller. It consumes DEBUG_READ / DEBUG_WRITE commands, meaning the 16-bit address register and 32-bit data register contents after Update-DR, already synchronized into the core clock domain. It decodes the ADP address map and runs single-beat req/ack transactions to the SRAM and the core debug port. It returns read data and an error flag for the TAP to capture on the next Capture-DR.

---
 rtl/adp_debug_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_adp_debug_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adp_debug_bridge.sv
// ADP debug bridge: turns synchronized DEBUG_READ/DEBUG_WRITE commands into single-beat
// SRAM / core-debug req/ack transactions. Optional REQ timeout under ADP_BRIDGE_TIMEOUT_EN.
module adp_debug_bridge #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       sram_req,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  input  logic [DATA_WIDTH-1:0]      sram_rdata,
  input  logic                       sram_ack,
  output logic                       core_req,
  output logic                       core_we,
  output logic [2:0]                 core_sel,
  output logic [4:0]                 core_idx,
  output logic [DATA_WIDTH-1:0]      core_wdata,
  input  logic [DATA_WIDTH-1:0]      core_rdata,
  input  logic                       core_ack
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {MASK_NONE, MASK_ADC, MASK_DAC} mask_t;

  state_t                       state_q, state_d;
  mask_t                        mask_q, mask_d;
  logic                         wr_q, wr_d;
  logic                         cmd_ready_q, cmd_ready_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                         rsp_err_q, rsp_err_d;
  logic                         sram_req_q, sram_req_d;
  logic                         sram_we_q, sram_we_d;
  logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]        sram_wdata_q, sram_wdata_d;
  logic                         core_req_q, core_req_d;
  logic                         core_we_q, core_we_d;
  logic [2:0]                   core_sel_q, core_sel_d;
  logic [4:0]                   core_idx_q, core_idx_d;
  logic [DATA_WIDTH-1:0]        core_wdata_q, core_wdata_d;
`ifdef ADP_BRIDGE_TIMEOUT_EN
  logic [7:0]                   wait_cnt_q, wait_cnt_d;
`endif

  logic       hit_sram, hit_x0, hit_gpr, hit_core, ack;
  logic [2:0] dec_sel;
  mask_t      dec_mask;
  logic [DATA_WIDTH-1:0] bus_rdata;

  // ADC exposes only bits [15:8], DAC only [7:0], in both directions
  function automatic logic [DATA_WIDTH-1:0] apply_mask(input mask_t m, input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (m == MASK_ADC) begin
      r = '0;
      r[15:8] = d[15:8];
    end else if (m == MASK_DAC) begin
      r = '0;
      r[7:0] = d[7:0];
    end
    return r;
  endfunction

  always_comb begin
    hit_sram = (cmd_addr[15:13] == 3'b001);
    hit_x0   = (cmd_addr == ADDR_WIDTH'(16'h4000));
    hit_gpr  = (cmd_addr[15:5] == 11'h200) && !hit_x0;
    hit_core = (cmd_addr[15:2] == 14'h2000);
    dec_sel  = 3'(cmd_addr[1:0]) + 3'd1;
    dec_mask = MASK_NONE;
    if (hit_core && cmd_addr[1:0] == 2'd2) dec_mask = MASK_ADC;
    if (hit_core && cmd_addr[1:0] == 2'd3) dec_mask = MASK_DAC;
    ack       = (sram_req_q & sram_ack) | (core_req_q & core_ack);
    bus_rdata = sram_req_q ? sram_rdata : apply_mask(mask_q, core_rdata);
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    wr_d         = wr_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    core_req_d   = core_req_q;
    core_we_d    = core_we_q;
    core_sel_d   = core_sel_q;
    core_idx_d   = core_idx_q;
    core_wdata_d = core_wdata_q;
`ifdef ADP_BRIDGE_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          wr_d        = cmd_write;
          mask_d      = dec_mask;
`ifdef ADP_BRIDGE_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
          if (hit_sram) begin
            sram_req_d   = 1'b1;
            sram_we_d    = cmd_write;
            sram_addr_d  = cmd_addr[SRAM_ADDR_WIDTH-1:0];
            sram_wdata_d = cmd_wdata;
            state_d      = REQ;
          end else if (hit_gpr || hit_core) begin
            core_req_d   = 1'b1;
            core_we_d    = cmd_write;
            core_sel_d   = hit_gpr ? 3'd0 : dec_sel;
            core_idx_d   = hit_gpr ? cmd_addr[4:0] : 5'd0;
            core_wdata_d = apply_mask(dec_mask, cmd_wdata);
            state_d      = REQ;
          end else begin
            // x0 and unmapped addresses complete locally without touching a bus
            rsp_valid_d = 1'b1;
            rsp_err_d   = !hit_x0;
            if (!cmd_write || !hit_x0) rsp_rdata_d = '0;
            state_d     = RESP;
          end
        end
      end
      REQ: begin
        if (ack) begin
          sram_req_d  = 1'b0;
          core_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!wr_q) rsp_rdata_d = bus_rdata;
          state_d     = RESP;
        end
`ifdef ADP_BRIDGE_TIMEOUT_EN
        else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          sram_req_d  = 1'b0;
          core_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          if (!wr_q) rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= MASK_NONE;
      wr_q         <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      core_req_q   <= 1'b0;
      core_we_q    <= 1'b0;
      core_sel_q   <= '0;
      core_idx_q   <= '0;
      core_wdata_q <= '0;
`ifdef ADP_BRIDGE_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      wr_q         <= wr_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      core_req_q   <= core_req_d;
      core_we_q    <= core_we_d;
      core_sel_q   <= core_sel_d;
      core_idx_q   <= core_idx_d;
      core_wdata_q <= core_wdata_d;
`ifdef ADP_BRIDGE_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign sram_req   = sram_req_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign core_req   = core_req_q;
  assign core_we    = core_we_q;
  assign core_sel   = core_sel_q;
  assign core_idx   = core_idx_q;
  assign core_wdata = core_wdata_q;

endmodule

// File: tb/tb_adp_debug_bridge.sv
// Directed bench for adp_debug_bridge: behavioural SRAM/core responders with programmable
// ack delay, and a scoreboard of expected responses checked whenever rsp_valid pulses.
module tb_adp_debug_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        sram_req, sram_we, sram_ack = 1'b0;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata = '0;
  logic        core_req, core_we, core_ack = 1'b0;
  logic [2:0]  core_sel;
  logic [4:0]  core_idx;
  logic [31:0] core_wdata, core_rdata = '0;

  adp_debug_bridge dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .core_req(core_req), .core_we(core_we), .core_sel(core_sel), .core_idx(core_idx),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   cyc = 0, accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Responders: ack for one cycle once req has been seen for <dly> cycles
  logic [31:0] sram_mem [int];
  int          sram_dly = 0, sram_cnt = 0, sram_req_cyc = 0;
  logic [12:0] last_sram_addr = '0;
  logic        last_sram_we = 1'b0;
  logic [31:0] last_sram_wdata = '0;

  always @(negedge clk) begin
    if (sram_req) sram_req_cyc++;
    if (sram_ack) sram_ack = 1'b0;
    else if (sram_req) begin
      if (sram_cnt == sram_dly) begin
        sram_ack = 1'b1;
        sram_cnt = 0;
        last_sram_addr  = sram_addr;
        last_sram_we    = sram_we;
        last_sram_wdata = sram_wdata;
        if (sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
        else sram_rdata = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 32'h0;
      end else sram_cnt++;
    end else sram_cnt = 0;
  end

  int          core_dly = 0, core_cnt = 0, core_req_cyc = 0;
  logic [31:0] core_rd_val = '0;
  logic [2:0]  last_core_sel = '0;
  logic [4:0]  last_core_idx = '0;
  logic        last_core_we = 1'b0;
  logic [31:0] last_core_wdata = '0;

  always @(negedge clk) begin
    if (core_req) core_req_cyc++;
    if (core_ack) core_ack = 1'b0;
    else if (core_req) begin
      if (core_cnt == core_dly) begin
        core_ack = 1'b1;
        core_cnt = 0;
        last_core_sel   = core_sel;
        last_core_idx   = core_idx;
        last_core_we    = core_we;
        last_core_wdata = core_wdata;
        if (!core_we) core_rdata = core_rd_val;
      end else core_cnt++;
    end else core_cnt = 0;
  end

  // Scoreboard monitor; latency counts edges from accept to the edge that samples rsp_valid
  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL rsp_unexpected got=1 exp=0");
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks += 3;
        assert (rsp_rdata === mon_e.rdata) else begin
          failures++;
          $error("FAIL rsp_rdata got=%08h exp=%08h", rsp_rdata, mon_e.rdata);
        end
        assert (rsp_err === mon_e.err) else begin
          failures++;
          $error("FAIL rsp_err got=%b exp=%b", rsp_err, mon_e.err);
        end
        assert ((cyc - accept_cyc + 1) == mon_e.lat) else begin
          failures++;
          $error("FAIL rsp_latency got=%0d exp=%0d", cyc - accept_cyc + 1, mon_e.lat);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'h1);
  endtask

  task automatic do_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input int el);
    exp_t e;
    int   n;
    e.rdata = er; e.err = ee; e.lat = el;
    exp_q.push_back(e);
    wait_ready();
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL rsp_wait got=none exp=rsp_valid addr=%04h", a);
      exp_q.delete();
    end
  endtask

  int snap_s, snap_c;

  initial begin
    // Reset state, then cmd_ready in the first cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_reqs", {30'h0, sram_req, core_req}, 32'h0);
    chk("rst_outs", 32'(sram_addr) | sram_wdata | core_wdata | 32'(core_sel) | 32'(core_idx)
                    | 32'(sram_we) | 32'(core_we), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);

    // SRAM round trip, 0-cycle ack delay
    sram_dly = 0;
    do_cmd(1'b1, 16'h2005, 32'hA5A5_1234, 32'h0, 1'b0, 2);
    chk("sram_wr_addr", 32'(last_sram_addr), 32'd5);
    chk("sram_wr_we", 32'(last_sram_we), 32'h1);
    chk("sram_wr_data", last_sram_wdata, 32'hA5A5_1234);
    do_cmd(1'b0, 16'h2005, 32'h0, 32'hA5A5_1234, 1'b0, 2);
    chk("sram_rd_we", 32'(last_sram_we), 32'h0);

    // SRAM round trip, 7-cycle ack delay
    sram_dly = 7;
    do_cmd(1'b1, 16'h2005, 32'hA5A5_1234, 32'hA5A5_1234, 1'b0, 9);
    do_cmd(1'b0, 16'h2005, 32'h0, 32'hA5A5_1234, 1'b0, 9);
    chk("sram_d7_addr", 32'(last_sram_addr), 32'd5);

    // GPR write and x0
    snap_s = sram_req_cyc;
    do_cmd(1'b1, 16'h401F, 32'h1, 32'hA5A5_1234, 1'b0, 2);
    chk("gpr_sel", 32'(last_core_sel), 32'd0);
    chk("gpr_idx", 32'(last_core_idx), 32'd31);
    chk("gpr_wdata", last_core_wdata, 32'h1);
    chk("gpr_no_sram", 32'(sram_req_cyc), 32'(snap_s));
    snap_c = core_req_cyc;
    do_cmd(1'b1, 16'h4000, 32'hFFFF_FFFF, 32'hA5A5_1234, 1'b0, 1);
    do_cmd(1'b0, 16'h4000, 32'h0, 32'h0, 1'b0, 1);
    chk("x0_no_core_req", 32'(core_req_cyc), 32'(snap_c));

    // ADC/DAC masking
    do_cmd(1'b1, 16'h8002, 32'hFFFF_FFFF, 32'h0, 1'b0, 2);
    chk("adc_sel", 32'(last_core_sel), 32'd3);
    chk("adc_wdata", last_core_wdata, 32'h0000_FF00);
    core_rd_val = 32'h1234_5678;
    do_cmd(1'b0, 16'h8003, 32'h0, 32'h0000_0078, 1'b0, 2);
    chk("dac_sel", 32'(last_core_sel), 32'd4);

    // PC with delayed ack, IR
    core_dly = 3; core_rd_val = 32'hDEAD_BEEF;
    do_cmd(1'b0, 16'h8000, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    chk("pc_sel", 32'(last_core_sel), 32'd1);
    core_dly = 0; core_rd_val = 32'h1122_3344;
    do_cmd(1'b0, 16'h8001, 32'h0, 32'h1122_3344, 1'b0, 2);
    chk("ir_sel", 32'(last_core_sel), 32'd2);

    // Unmapped addresses complete locally with error; a good access clears it
    snap_s = sram_req_cyc; snap_c = core_req_cyc;
    do_cmd(1'b0, 16'h9000, 32'h0, 32'h0, 1'b1, 1);
    do_cmd(1'b0, 16'h4020, 32'h0, 32'h0, 1'b1, 1);
    chk("unmapped_no_req", 32'(sram_req_cyc + core_req_cyc), 32'(snap_s + snap_c));
    core_rd_val = 32'hCAFE_0001;
    do_cmd(1'b0, 16'h4003, 32'h0, 32'hCAFE_0001, 1'b0, 2);
    chk("gpr_rd_idx", 32'(last_core_idx), 32'd3);

`ifdef ADP_BRIDGE_TIMEOUT_EN
    core_dly = 1000;
    do_cmd(1'b0, 16'h8000, 32'h0, 32'h0, 1'b1, 256);
    core_dly = 254; core_rd_val = 32'h0BAD_F00D;
    do_cmd(1'b0, 16'h8000, 32'h0, 32'h0BAD_F00D, 1'b0, 256);
`endif

    // Reset while a core request is outstanding: req drops, response is lost
    core_dly = 50;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h8000;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("req_before_rst", 32'(core_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_drop", 32'(core_req), 32'h0);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_rdata_clear", rsp_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
